udp_rx_header_strip: RTL and testbench

UDP_RX_HEADER_STRIP -- requirements
Module: udp_rx_header_strip

---
 rtl/udp_rx_header_strip.sv | 130 +++++++++++++
 tb/tb_udp_rx_header_strip.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_rx_header_strip.sv
// UDP receive header stripper: parses the 8-byte UDP header from an 8-bit IP payload
// stream, publishes the header fields and forwards the payload with one cycle latency.
module udp_rx_header_strip (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cfg_local_port,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        m_valid,
    output logic [7:0]  m_data,
    output logic        m_last,
    output logic        hdr_valid,
    output logic [15:0] src_port,
    output logic [15:0] dst_port,
    output logic [15:0] udp_len,
    output logic [15:0] udp_csum,
    output logic        err_len,
    output logic        err_port
);

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        PAY  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      state_r;
    logic [2:0]  hdr_cnt_r;
    logic [15:0] pay_cnt_r;
    logic [55:0] hdr_buf_r;

    logic [63:0] hdr_full_s;
    logic [15:0] len_s;
    logic [15:0] dst_s;
    logic        len_bad_s;
    logic        port_bad_s;

    // Complete header as seen while header byte 7 is on the input.
    assign hdr_full_s = {hdr_buf_r, s_data};
    assign dst_s      = hdr_full_s[47:32];
    assign len_s      = hdr_full_s[31:16];
    assign len_bad_s  = (len_s < 16'd8);
    assign port_bad_s = (cfg_local_port != 16'd0) && (dst_s != cfg_local_port);

    // Parser state machine with all outputs registered; strobes default low each cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= HDR;
            hdr_cnt_r <= 3'd0;
            pay_cnt_r <= 16'd0;
            hdr_buf_r <= 56'd0;
            m_valid   <= 1'b0;
            m_data    <= 8'd0;
            m_last    <= 1'b0;
            hdr_valid <= 1'b0;
            src_port  <= 16'd0;
            dst_port  <= 16'd0;
            udp_len   <= 16'd0;
            udp_csum  <= 16'd0;
            err_len   <= 1'b0;
            err_port  <= 1'b0;
        end else begin
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            hdr_valid <= 1'b0;
            err_len   <= 1'b0;
            err_port  <= 1'b0;
            if (s_valid) begin
                case (state_r)
                    HDR: begin
                        hdr_buf_r <= hdr_full_s[55:0];
                        if (hdr_cnt_r == 3'd7) begin
                            hdr_cnt_r <= 3'd0;
                            hdr_valid <= 1'b1;
                            src_port  <= hdr_full_s[63:48];
                            dst_port  <= dst_s;
                            udp_len   <= len_s;
                            udp_csum  <= hdr_full_s[15:0];
                            err_len   <= len_bad_s;
                            err_port  <= port_bad_s;
                            if (len_bad_s || port_bad_s || (len_s == 16'd8)) begin
                                state_r <= s_last ? HDR : DROP;
                            end else if (s_last) begin
                                // Frame ended where payload was promised: truncated datagram.
                                err_len <= 1'b1;
                                state_r <= HDR;
                            end else begin
                                pay_cnt_r <= len_s - 16'd8;
                                state_r   <= PAY;
                            end
                        end else if (s_last) begin
                            err_len   <= 1'b1;
                            hdr_cnt_r <= 3'd0;
                        end else begin
                            hdr_cnt_r <= hdr_cnt_r + 3'd1;
                        end
                    end
                    PAY: begin
                        m_valid   <= 1'b1;
                        m_data    <= s_data;
                        pay_cnt_r <= pay_cnt_r - 16'd1;
                        if (pay_cnt_r == 16'd1) begin
                            m_last  <= 1'b1;
                            state_r <= s_last ? HDR : DROP;
                        end else if (s_last) begin
                            m_last  <= 1'b1;
                            err_len <= 1'b1;
                            state_r <= HDR;
                        end else begin
                            state_r <= PAY;
                        end
                    end
                    DROP: begin
                        if (s_last) begin
                            state_r <= HDR;
                        end else begin
                            state_r <= DROP;
                        end
                    end
                    default: begin
                        state_r   <= HDR;
                        hdr_cnt_r <= 3'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_udp_rx_header_strip.sv
// Self-checking bench for udp_rx_header_strip: table of frames, a frame-level reference
// model feeding a scoreboard queue, and a hand-written reset-during-payload sequence.
module tb_udp_rx_header_strip;

    logic        clk;
    logic        rst;
    logic [15:0] cfg_local_port;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_last;
    logic        hdr_valid;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] udp_len;
    logic [15:0] udp_csum;
    logic        err_len;
    logic        err_port;

    udp_rx_header_strip dut (
        .clk(clk), .rst(rst), .cfg_local_port(cfg_local_port),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
        .hdr_valid(hdr_valid), .src_port(src_port), .dst_port(dst_port),
        .udp_len(udp_len), .udp_csum(udp_csum),
        .err_len(err_len), .err_port(err_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]  cfg;
        logic [191:0] bytes;     // right-justified: byte 0 is the most significant of n
        int           n;
        bit           gaps;
        bit           has_last;
        int           exp_npay;
        bit           exp_hdr;
        bit           exp_errl;
        bit           exp_errp;
    } vec_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic        mv;
        logic [7:0]  md;
        logic        ml;
        logic        hv;
        logic        el;
        logic        ep;
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] len;
        logic [15:0] csum;
    } obs_t;

    obs_t        sbq[$];
    obs_t        exp_b[0:23];
    bit          exp_has[0:23];
    logic [15:0] md_src, md_dst, md_len, md_csum;
    int          cyc;
    int          n_checks;
    int          n_fail;
    int          obs_pay, obs_hdr, obs_errl, obs_errp;
    vec_t        vecs[11];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input vec_t v, input int i);
        return v.bytes[8*(v.n-1-i) +: 8];
    endfunction

    function automatic vec_t mk(input logic [15:0] c, input logic [191:0] b, input int n,
                                input bit g, input int np, input bit h, input bit el, input bit ep);
        vec_t v;
        v.cfg = c; v.bytes = b; v.n = n; v.gaps = g; v.has_last = 1'b1;
        v.exp_npay = np; v.exp_hdr = h; v.exp_errl = el; v.exp_errp = ep;
        return v;
    endfunction

    // Frame-level reference: which input byte produces which output cycle.
    task automatic build_model(input vec_t v);
        int plen, avail, k, idx;
        for (int i = 0; i < 24; i++) begin
            exp_has[i] = 1'b0;
            exp_b[i]   = '0;
        end
        if (v.n < 8) begin
            if (v.has_last && v.n > 0) begin
                exp_has[v.n-1]  = 1'b1;
                exp_b[v.n-1].el = 1'b1;
            end
        end else begin
            md_src  = {byte_at(v, 0), byte_at(v, 1)};
            md_dst  = {byte_at(v, 2), byte_at(v, 3)};
            md_len  = {byte_at(v, 4), byte_at(v, 5)};
            md_csum = {byte_at(v, 6), byte_at(v, 7)};
            exp_has[7]  = 1'b1;
            exp_b[7].hv = 1'b1;
            exp_b[7].el = (md_len < 16'd8);
            exp_b[7].ep = (v.cfg != 16'd0) && (md_dst != v.cfg);
            if (!exp_b[7].el && !exp_b[7].ep && md_len != 16'd8) begin
                plen  = int'(md_len) - 8;
                avail = v.n - 8;
                k     = (avail < plen) ? avail : plen;
                for (int j = 0; j < k; j++) begin
                    idx = 8 + j;
                    exp_has[idx]  = 1'b1;
                    exp_b[idx].mv = 1'b1;
                    exp_b[idx].md = byte_at(v, idx);
                    if (j == k - 1) begin
                        exp_b[idx].ml = (k == plen) || v.has_last;
                        exp_b[idx].el = v.has_last && (avail < plen);
                    end
                end
            end
        end
        for (int i = 0; i < 24; i++) begin
            exp_b[i].src = md_src; exp_b[i].dst = md_dst;
            exp_b[i].len = md_len; exp_b[i].csum = md_csum;
        end
    endtask

    task automatic drive_frame(input vec_t v);
        obs_t rec;
        build_model(v);
        for (int i = 0; i < v.n; i++) begin
            if (v.gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    s_valid = 1'b0;
                    s_data  = 8'($urandom);
                    s_last  = 1'($urandom);
                end
            end
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = byte_at(v, i);
            s_last  = v.has_last && (i == v.n - 1);
            if (exp_has[i]) begin
                rec     = exp_b[i];
                rec.cyc = 32'(cyc + 1);
                sbq.push_back(rec);
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Scoreboard monitor, sampling one delta-safe step after each rising edge.
    always @(posedge clk) begin
        obs_t act;
        obs_t exp;
        #1;
        while (rst && sbq.size() > 0 && int'(sbq[0].cyc) < cyc) begin
            exp = sbq.pop_front();
            chk("missing output", 128'(0), 128'(exp));
        end
        if (rst && (m_valid || hdr_valid || err_len || err_port)) begin
            act = {32'(cyc), m_valid, m_data, m_last, hdr_valid, err_len, err_port,
                   src_port, dst_port, udp_len, udp_csum};
            if (m_valid)   obs_pay++;
            if (hdr_valid) obs_hdr++;
            if (err_len)   obs_errl++;
            if (err_port)  obs_errp++;
            if (sbq.size() == 0) begin
                chk("unexpected output", 128'(act), 128'(0));
            end else begin
                exp = sbq.pop_front();
                if (!exp.mv) begin
                    exp.md = 8'd0;
                    act.md = 8'd0;
                end
                chk("output cycle", 128'(act), 128'(exp));
            end
        end
    end

    task automatic frame_counts(input string name, input vec_t v);
        chk({name, " npay"}, 128'(obs_pay), 128'(v.exp_npay));
        chk({name, " hdr"},  128'(obs_hdr), 128'(v.exp_hdr));
        chk({name, " errl"}, 128'(obs_errl), 128'(v.exp_errl));
        chk({name, " errp"}, 128'(obs_errp), 128'(v.exp_errp));
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({m_valid, m_data, m_last, hdr_valid, src_port, dst_port,
                     udp_len, udp_csum, err_len, err_port});
    endfunction

    initial begin
        vec_t v;
        n_checks = 0; n_fail = 0; cyc = 0;
        md_src = 16'd0; md_dst = 16'd0; md_len = 16'd0; md_csum = 16'd0;
        rst = 1'b0; cfg_local_port = 16'd0;
        s_valid = 1'b0; s_data = 8'd0; s_last = 1'b0;

        vecs[0]  = mk(16'h1388, 192'h1388_1388_000C_ABCD_DEAD_BEEF, 12, 1'b0, 4, 1'b1, 1'b0, 1'b0);
        vecs[1]  = mk(16'h1388, 192'h1388_1388_000C_ABCD_DEAD_BEEF_0000_0000_0000, 18, 1'b0, 4, 1'b1, 1'b0, 1'b0);
        vecs[2]  = mk(16'h1388, 192'h1234_0050_000A_0000_1122, 10, 1'b0, 0, 1'b1, 1'b0, 1'b1);
        vecs[3]  = mk(16'h1388, 192'h1234_1388_0004_0000_5566, 10, 1'b0, 0, 1'b1, 1'b1, 1'b0);
        vecs[4]  = mk(16'h1388, 192'h1234_1388_0010_1111_0102_0304, 12, 1'b0, 4, 1'b1, 1'b1, 1'b0);
        vecs[5]  = mk(16'h1388, 192'h01_0203_0405, 5, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        vecs[6]  = mk(16'h0000, 192'h4321_9999_0009_FFFF_7A, 9, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        vecs[7]  = mk(16'h0000, 192'h0001_0002_0008_0003, 8, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        vecs[8]  = mk(16'h1388, 192'h1234_0051_0002_0000_9999, 10, 1'b0, 0, 1'b1, 1'b1, 1'b1);
        vecs[9]  = mk(16'h1388, 192'h1388_1388_000C_ABCD_DEAD_BEEF, 12, 1'b1, 4, 1'b1, 1'b0, 1'b0);
        vecs[10] = mk(16'h0000, 192'h0001_0002_0008_0003_AABB, 10, 1'b0, 0, 1'b1, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("reset outputs", all_outs(), 128'(0));
        rst = 1'b1;

        foreach (vecs[i]) begin
            cfg_local_port = vecs[i].cfg;
            obs_pay = 0; obs_hdr = 0; obs_errl = 0; obs_errp = 0;
            drive_frame(vecs[i]);
            repeat (3) @(negedge clk);
            frame_counts($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset asserted while the payload of an unterminated datagram is streaming.
        cfg_local_port = 16'h1388;
        v = mk(16'h1388, 192'h1388_1388_000C_ABCD_DEAD, 10, 1'b0, 2, 1'b1, 1'b0, 1'b0);
        v.has_last = 1'b0;
        drive_frame(v);
        chk("pre-reset m_valid", 128'(m_valid), 128'(1));
        rst = 1'b0;
        #1;
        chk("reset mid-pay outputs", all_outs(), 128'(0));
        md_src = 16'd0; md_dst = 16'd0; md_len = 16'd0; md_csum = 16'd0;
        repeat (2) @(negedge clk);
        chk("reset hold outputs", all_outs(), 128'(0));
        chk("queue drained at reset", 128'(sbq.size()), 128'(0));
        rst = 1'b1;
        obs_pay = 0; obs_hdr = 0; obs_errl = 0; obs_errp = 0;
        drive_frame(vecs[0]);
        repeat (3) @(negedge clk);
        frame_counts("post-reset", vecs[0]);
        chk("post-reset src", 128'(src_port), 128'(16'h1388));
        chk("post-reset csum", 128'(udp_csum), 128'(16'hABCD));

        repeat (2) @(negedge clk);
        chk("scoreboard empty", 128'(sbq.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
